// File: rtl/symbol_timing_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : symbol_timing_pkg
//  Purpose  : Shared types and constants for the symbol-timing arbiter:
//             input FSM state encoding, the 1-bit port tag, default width.
//  Revision : 1.0  initial release
// ============================================================================
package symbol_timing_pkg;

    // Default packed I/Q sample width.
    localparam int c_default_width = 32;

    // Input-side arbitration states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Owner tag carried through the tag FIFO: 0 = port 0, 1 = port 1.
    typedef logic tag_t;

endpackage
`default_nettype wire

// File: rtl/symbol_timing_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : symbol_timing_arbiter_if
//  Purpose  : One AXI-Stream link (tdata/tlast/tvalid/tready).
//  Ports    : master modport drives tdata/tlast/tvalid and samples tready;
//             slave modport is the mirror image.
//  Revision : 1.0  initial release
// ============================================================================
interface symbol_timing_arbiter_if
    import symbol_timing_pkg::*;
    #(parameter int WIDTH = c_default_width);

    logic [WIDTH-1:0] tdata;
    logic             tlast;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tlast, output tvalid, input  tready);
    modport slave  (input  tdata, input  tlast, input  tvalid, output tready);

endinterface
`default_nettype wire

// File: rtl/symbol_timing_arbiter_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tag_fifo
//  Purpose  : Synchronous FIFO of 1-bit owner tags, depth 2**AWIDTH.
//  Ports    : clk, reset (async, active-high), clear (sync flush),
//             push/push_tag, pop, head (registered head entry),
//             full, empty, count (occupancy, AWIDTH+1 bits).
//  Revision : 1.0  initial release
// ============================================================================
module tag_fifo
    import symbol_timing_pkg::*;
    #(parameter int AWIDTH = 3)
(
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              clear,
    input  wire logic              push,
    input  wire tag_t              push_tag,
    input  wire logic              pop,
    output tag_t                   head,
    output logic                   full,
    output logic                   empty,
    output logic [AWIDTH:0]        count
);

    localparam int              c_depth      = 1 << AWIDTH;
    localparam logic [AWIDTH:0] c_full_count = (AWIDTH+1)'(c_depth);

    tag_t              r_mem [c_depth];
    logic [AWIDTH:0]   r_wr_ptr;
    logic [AWIDTH:0]   r_rd_ptr;
    logic              w_do_push;
    logic              w_do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count     = r_wr_ptr - r_rd_ptr;
    assign full      = (count == c_full_count);
    assign empty     = (count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign head      = r_mem[r_rd_ptr[AWIDTH-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only observed while non-empty.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AWIDTH-1:0]] <= push_tag;
    end

endmodule
`default_nettype wire

// File: rtl/symbol_timing_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : symbol_timing_arbiter
//  Purpose  : Packet-atomic round-robin arbiter sharing one SymbolTiming core
//             between two sample streams. A tag FIFO remembers the owner of
//             every in-flight packet so core output packets are routed back
//             to the matching downstream port.
//  Ports    : clk, reset (async, active-high), clear (sync flush)
//             s0, s1     : slave  streams from the two requesters
//             core_i     : master stream into the core
//             core_o     : slave  stream from the core
//             m0, m1     : master streams to the per-port outputs
//             grant      : one-hot current input owner, 00 = idle
//             tag_err    : sticky, core emitted data with no tag pending
//             pkt_cnt0/1 : accepted input packets per port (optional)
//  Options  : SYMBOL_TIMING_ARB_STATS_EN adds pkt_cnt0/pkt_cnt1.
//  Revision : 1.0  initial release
// ============================================================================
module symbol_timing_arbiter
    import symbol_timing_pkg::*;
    #(
        parameter int WIDTH      = c_default_width,
        parameter int TAG_AWIDTH = 3
    )
(
    input  wire logic                       clk,
    input  wire logic                       reset,
    input  wire logic                       clear,
    symbol_timing_arbiter_if.slave          s0,
    symbol_timing_arbiter_if.slave          s1,
    symbol_timing_arbiter_if.master         core_i,
    symbol_timing_arbiter_if.slave          core_o,
    symbol_timing_arbiter_if.master         m0,
    symbol_timing_arbiter_if.master         m1,
    output logic [1:0]                      grant,
`ifdef SYMBOL_TIMING_ARB_STATS_EN
    output logic [31:0]                     pkt_cnt0,
    output logic [31:0]                     pkt_cnt1,
`endif
    output logic                            tag_err
);

    arb_state_t            r_state;
    logic                  r_last_owner;
    logic [1:0]            r_grant;
    logic                  r_tag_err;

    logic                  w_own0;
    logic                  w_own1;
    logic                  w_pick1;
    logic                  w_req;
    logic                  w_push;
    logic                  w_pop;
    logic [WIDTH-1:0]      w_ci_data;

    tag_t                  w_head;
    logic                  w_full;
    logic                  w_empty;
    logic [TAG_AWIDTH:0]   w_count;

    // ------------------------------------------------------------------
    // Arbitration decision (only acted on in IDLE)
    // ------------------------------------------------------------------
    // Port 1 wins if it is the only requester, or both request and port 0
    // owned the previous packet.
    assign w_req   = s0.tvalid || s1.tvalid;
    assign w_pick1 = s1.tvalid && (!s0.tvalid || (r_last_owner == 1'b0));
    assign w_push  = (r_state == IDLE) && w_req && !w_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_owner <= 1'b1;
            r_grant      <= 2'b00;
        end else if (clear) begin
            r_state      <= IDLE;
            r_last_owner <= 1'b1;
            r_grant      <= 2'b00;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_push) begin
                        if (w_pick1) begin
                            r_state      <= OWN1;
                            r_grant      <= 2'b10;
                            r_last_owner <= 1'b1;
                        end else begin
                            r_state      <= OWN0;
                            r_grant      <= 2'b01;
                            r_last_owner <= 1'b0;
                        end
                    end
                end
                OWN0: begin
                    if (s0.tvalid && core_i.tready && s0.tlast) begin
                        r_state <= IDLE;
                        r_grant <= 2'b00;
                    end
                end
                OWN1: begin
                    if (s1.tvalid && core_i.tready && s1.tlast) begin
                        r_state <= IDLE;
                        r_grant <= 2'b00;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Input routing: pure combinational pass-through of the granted port
    // ------------------------------------------------------------------
    assign w_own0    = (r_state == OWN0);
    assign w_own1    = (r_state == OWN1);
    assign w_ci_data = w_own1 ? s1.tdata : s0.tdata;

    assign core_i.tdata  = w_ci_data;
    assign core_i.tlast  = w_own1 ? s1.tlast : s0.tlast;
    assign core_i.tvalid = (w_own0 && s0.tvalid) || (w_own1 && s1.tvalid);
    assign s0.tready     = w_own0 && core_i.tready;
    assign s1.tready     = w_own1 && core_i.tready;

    // ------------------------------------------------------------------
    // Tag FIFO
    // ------------------------------------------------------------------
    tag_fifo #(
        .AWIDTH   (TAG_AWIDTH)
    ) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .push     (w_push),
        .push_tag (w_pick1),
        .pop      (w_pop),
        .head     (w_head),
        .full     (w_full),
        .empty    (w_empty),
        .count    (w_count)
    );

    // ------------------------------------------------------------------
    // Output routing: head tag steers core_o to m0 or m1
    // ------------------------------------------------------------------
    assign m0.tdata      = core_o.tdata;
    assign m0.tlast      = core_o.tlast;
    assign m1.tdata      = core_o.tdata;
    assign m1.tlast      = core_o.tlast;
    assign m0.tvalid     = !w_empty && (w_head == 1'b0) && core_o.tvalid;
    assign m1.tvalid     = !w_empty && (w_head == 1'b1) && core_o.tvalid;
    assign core_o.tready = !w_empty && ((w_head == 1'b1) ? m1.tready : m0.tready);
    assign w_pop         = core_o.tvalid && core_o.tready && core_o.tlast;

    // Core output with no pending tag means the core broke the one-out-per-
    // one-in contract; latch it until the next reset or clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tag_err <= 1'b0;
        end else if (clear) begin
            r_tag_err <= 1'b0;
        end else if (core_o.tvalid && (w_count == '0)) begin
            r_tag_err <= 1'b1;
        end
    end

    assign grant   = r_grant;
    assign tag_err = r_tag_err;

`ifdef SYMBOL_TIMING_ARB_STATS_EN
    logic [31:0] r_pkt_cnt0;
    logic [31:0] r_pkt_cnt1;
    logic        w_last0;
    logic        w_last1;

    assign w_last0 = w_own0 && s0.tvalid && core_i.tready && s0.tlast;
    assign w_last1 = w_own1 && s1.tvalid && core_i.tready && s1.tlast;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pkt_cnt0 <= '0;
            r_pkt_cnt1 <= '0;
        end else if (clear) begin
            r_pkt_cnt0 <= '0;
            r_pkt_cnt1 <= '0;
        end else begin
            if (w_last0) r_pkt_cnt0 <= r_pkt_cnt0 + 32'd1;
            if (w_last1) r_pkt_cnt1 <= r_pkt_cnt1 + 32'd1;
        end
    end

    assign pkt_cnt0 = r_pkt_cnt0;
    assign pkt_cnt1 = r_pkt_cnt1;
`endif

endmodule
`default_nettype wire

// File: doc/symbol_timing_arbiter.md
# symbol_timing_arbiter

Packet-atomic round-robin arbiter that shares one SymbolTiming core between two sample streams. Sits between two upstream AXI-Stream sources (e.g. two antenna/channel paths after their input pipeline flops) and the single core. A tag FIFO records which port owns each in-flight packet, so the core's output packets are routed back to the matching downstream port.

## Interface
- `WIDTH`, 32: sample width (packed I/Q).
- `TAG_AWIDTH`, 3: log2 of the tag FIFO depth, i.e. the number of packets allowed in flight inside the core.
- `clk`  in  1: clock, single domain.
- `reset`  in  1: asynchronous, active-high.
- `clear`  in  1: synchronous flush, strobed at block init (clear_tx_seqnum).
- `s0_tdata`/`s0_tlast`/`s0_tvalid`/`s0_tready`  in/in/in/out  WIDTH/1/1/1: requester 0 input.
- `s1_tdata`/`s1_tlast`/`s1_tvalid`/`s1_tready`  in/in/in/out  WIDTH/1/1/1: requester 1 input.
- `core_i_tdata`/`core_i_tlast`/`core_i_tvalid`/`core_i_tready`  out/out/out/in  WIDTH/1/1/1: to the core input.
- `core_o_tdata`/`core_o_tlast`/`core_o_tvalid`/`core_o_tready`  in/in/in/out  WIDTH/1/1/1: from the core output.
- `m0_*`, `m1_*`  out/out/out/in  WIDTH/1/1/1: per-port outputs (tdata, tlast, tvalid, tready).
- `grant`  out  2: one-hot current input owner; 00 means idle.
- `tag_err`  out  1: sticky flag, set when the core emits data while the tag FIFO is empty.

## Operation
- Input FSM states:
  - IDLE: evaluate requests.
  - OWN0: s0 is connected to core_i.
  - OWN1: s1 is connected to core_i.
- IDLE to OWNx:
  - Requires `sx_tvalid` and tag FIFO not full.
  - If both ports are valid, the port other than `last_owner` wins. `last_owner` resets to 1, so port 0 wins first.
  - On entry, push tag x into the FIFO and update `last_owner`.
- In OWNx:
  - `core_i_*` = `sx_*`, and `sx_tready` = `core_i_tready`.
  - The other port's tready is 0.
  - The grant holds until a beat with `tlast` is accepted (tvalid & tready & tlast), then the FSM returns to IDLE.
- Packets are never interleaved on core_i.
- Output side:
  - When the FIFO is non-empty, its head tag selects the output: `mH_*` = `core_o_*`, `core_o_tready` = `mH_tready`. The non-selected output has tvalid 0.
  - Pop on the accepted `core_o` beat with tlast.
  - FIFO empty: `core_o_tready` = 0, both `m*_tvalid` = 0. If `core_o_tvalid` = 1 in this condition, set `tag_err`.
- The core must emit exactly one output packet per input packet.
- Tag FIFO push and pop in the same cycle: occupancy unchanged. A push at full is impossible by construction.
- `clear` and `reset` both:
  - Return the FSM to IDLE, empty the FIFO, set `last_owner` to 1 and clear `tag_err`.
  - A partial packet mid-grant is abandoned. The core is cleared by the same strobe.

## Timing
- Values during reset:
  - All tready and tvalid outputs are 0.
  - `grant` = 00.
  - `tag_err` = 0.
- Input path: combinational pass-through while granted, zero added latency.
- Arbitration: one bubble cycle in IDLE between packets. A granted port's first beat can transfer in the cycle after the grant register updates.
- Output path: combinational mux from the registered FIFO head, zero latency. The first beat of the next packet can pass in the cycle after the tlast pop.
- All handshakes follow AXI-Stream rules: tvalid is never gated by tready, and no combinational tready→tvalid loop is added.
- A single-beat packet (tlast on the first beat) is legal. It takes 2 cycles including IDLE.

## Configuration
- `SYMBOL_TIMING_ARB_STATS_EN`:
  - Defined: adds output ports `pkt_cnt0` and `pkt_cnt1` (32 bits each). Each increments on every accepted input tlast of its port, wraps at 2^32, and is zeroed by reset or clear.
  - Undefined: these ports and their counters do not exist.

## Structure
- Shared package `symbol_timing_pkg`:
  - FSM state enum (IDLE, OWN0, OWN1).
  - Tag type (1 bit).
  - Default `WIDTH`.
- Sub-module `tag_fifo`: synchronous FIFO, 1-bit data, depth 2^TAG_AWIDTH, with full, empty and count outputs, asynchronous reset and synchronous clear.
- Arbiter FSM and routing muxes live in the top level.

## Test plan
- Only s0 sends 3 packets of 4 beats; core modelled as a 2-cycle delay line → m0 receives 12 beats with tlast on beats 4/8/12; m1 never asserts tvalid; `grant` = 01 only.
- s0 and s1 both stream continuously, 8-beat packets → core_i order is s0, s1, s0, s1 with no interleaving inside a packet; each m port receives only its own data (tags the payload per source).
- TAG_AWIDTH = 1 and core_o_tready stalled (m0/m1 tready = 0) → after 2 packets are granted, `grant` stays 00 despite s0_tvalid; releasing tready resumes grants.
- Core model injects one beat while the FIFO is empty → `tag_err` = 1 and stays 1; `core_o_tready` = 0 that cycle.
- `clear` asserted on beat 3 of a 6-beat s1 packet → next cycle `grant` = 00, FIFO empty; the next s0 packet is granted first.
- Async `reset` asserted between clock edges mid-transfer → all tvalid/tready outputs drop to 0 immediately; counters (with `SYMBOL_TIMING_ARB_STATS_EN`) read 0.
